// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the MIPS-subset cpu datapath.
// The $29 initial value is held by the datapath. This block only selects it,
// through MemToReg=100 in the post-reset cycle.
module control_unit #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Overflow,
  input  logic       Igual,
  output logic       PC_write,
  output logic       A_write,
  output logic       B_write,
  output logic       ALUOut_write,
  output logic       EPC_write,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       FlagRegWrite,
  output logic       HI_write,
  output logic       LO_write,
  output logic       IorD,
  output logic       seletor_ulaA,
  output logic [1:0] seletor_ulaB,
  output logic [2:0] Seletor,
  output logic [2:0] ShiftOP,
  output logic [1:0] RegDst,
  output logic [2:0] MemToReg,
  output logic [1:0] PCSource,
  output logic       exc_cause,
  output logic [4:0] state_dbg
);

  localparam int unsigned CNT_W = $clog2(MEM_WAIT + 2);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  typedef enum logic [4:0] {
    RST    = 5'd0,
    FETCH  = 5'd1,
    DECODE = 5'd2,
    EXEC_R = 5'd3,
    WB_R   = 5'd4,
    EXEC_I = 5'd5,
    WB_I   = 5'd6,
    SH_LD  = 5'd7,
    SH_OP  = 5'd8,
    SH_WB  = 5'd9,
    JR     = 5'd10,
    J      = 5'd11,
    JAL    = 5'd12,
    BR     = 5'd13,
    ADDR   = 5'd14,
    LW_RD  = 5'd15,
    SW     = 5'd16,
    EXC    = 5'd17
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cause, cause_n;
  logic             wait_done;

  assign wait_done = (cnt == CNT_W'(MEM_WAIT));

  // State, memory-wait counter and exception cause registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RST;
      cnt   <= '0;
      cause <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cause <= cause_n;
    end
  end

  // Next-state and Moore control decode; everything forced low while in reset
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    cause_n      = cause;
    PC_write     = 1'b0;
    A_write      = 1'b0;
    B_write      = 1'b0;
    ALUOut_write = 1'b0;
    EPC_write    = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    FlagRegWrite = 1'b0;
    HI_write     = 1'b0;
    LO_write     = 1'b0;
    IorD         = 1'b0;
    seletor_ulaA = 1'b0;
    seletor_ulaB = 2'b00;
    Seletor      = 3'b000;
    ShiftOP      = 3'b000;
    RegDst       = 2'b00;
    MemToReg     = 3'b000;
    PCSource     = 2'b00;
    exc_cause    = 1'b0;
    state_dbg    = 5'd0;
    if (reset) begin
      state_dbg = state;
      case (state)
        RST: begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemToReg = 3'b100;
          state_n  = FETCH;
          cnt_n    = '0;
        end
        FETCH: begin
          seletor_ulaB = 2'b01;
          Seletor      = 3'b001;
          if (wait_done) begin
            IRWrite  = 1'b1;
            PC_write = 1'b1;
            state_n  = DECODE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        DECODE: begin
          A_write      = 1'b1;
          B_write      = 1'b1;
          ALUOut_write = 1'b1;
          seletor_ulaB = 2'b11;
          Seletor      = 3'b001;
          cause_n      = 1'b0;
          case (opcode)
            OP_R: begin
              case (funct)
                FN_ADD, FN_SUB, FN_AND: state_n = EXEC_R;
                FN_SLL, FN_SRL:         state_n = SH_LD;
                FN_JR:                  state_n = JR;
                default:                state_n = EXC;
              endcase
            end
            OP_ADDI:      state_n = EXEC_I;
            OP_LW, OP_SW: state_n = ADDR;
            OP_BEQ, OP_BNE: state_n = BR;
            OP_J:         state_n = J;
            OP_JAL:       state_n = JAL;
            default:      state_n = EXC;
          endcase
        end
        EXEC_R: begin
          seletor_ulaA = 1'b1;
          ALUOut_write = 1'b1;
          FlagRegWrite = 1'b1;
          case (funct)
            FN_ADD:  Seletor = 3'b001;
            FN_SUB:  Seletor = 3'b010;
            default: Seletor = 3'b011;
          endcase
          if (Overflow && (funct == FN_ADD || funct == FN_SUB)) begin
            state_n = EXC;
            cause_n = 1'b1;
          end else begin
            state_n = WB_R;
          end
        end
        EXEC_I: begin
          seletor_ulaA = 1'b1;
          seletor_ulaB = 2'b10;
          Seletor      = 3'b001;
          ALUOut_write = 1'b1;
          FlagRegWrite = 1'b1;
          if (Overflow) begin
            state_n = EXC;
            cause_n = 1'b1;
          end else begin
            state_n = WB_I;
          end
        end
        SH_LD: begin
          ShiftOP = 3'b001;
          state_n = SH_OP;
        end
        SH_OP: begin
          ShiftOP = (funct == FN_SRL) ? 3'b011 : 3'b010;
          state_n = SH_WB;
        end
        ADDR: begin
          seletor_ulaA = 1'b1;
          seletor_ulaB = 2'b10;
          Seletor      = 3'b001;
          ALUOut_write = 1'b1;
          if (opcode == OP_LW) begin
            state_n = LW_RD;
            cnt_n   = '0;
          end else begin
            state_n = SW;
          end
        end
        LW_RD: begin
          IorD = 1'b1;
          if (wait_done) begin
            RegWrite = 1'b1;
            MemToReg = 3'b001;
            state_n  = FETCH;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          // Single-cycle terminal states all return to FETCH
          state_n = FETCH;
          cnt_n   = '0;
          case (state)
            WB_R: begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
            end
            WB_I: RegWrite = 1'b1;
            SH_WB: begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
              MemToReg = 3'b010;
            end
            JR: begin
              seletor_ulaA = 1'b1;
              PC_write     = 1'b1;
            end
            J: begin
              PC_write = 1'b1;
              PCSource = 2'b10;
            end
            JAL: begin
              RegWrite = 1'b1;
              RegDst   = 2'b11;
              MemToReg = 3'b011;
              PC_write = 1'b1;
              PCSource = 2'b10;
            end
            BR: begin
              seletor_ulaA = 1'b1;
              Seletor      = 3'b111;
              PC_write     = (opcode == OP_BEQ) ? Igual : ~Igual;
              PCSource     = 2'b01;
            end
            SW: begin
              IorD     = 1'b1;
              MemWrite = 1'b1;
            end
            EXC: begin
              EPC_write    = 1'b1;
              seletor_ulaB = 2'b01;
              Seletor      = 3'b010;
              PC_write     = 1'b1;
              PCSource     = 2'b11;
              exc_cause    = cause;
            end
            default: state_n = RST;
          endcase
        end
      endcase
    end
  end

endmodule
